// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared UART constants, FSM state encoding, vote helper         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int OVERSAMPLE_DEF = 16;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_tick : divide-by-DIV tick generator with synchronous clear      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == C_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clearing restarts the period, so the first tick lands DIV clocks later.
  assign tick = !clr && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx : oversampling 8-bit UART receiver with 3-sample majority vote    |
// | Optional even parity: define UART_RX_PARITY_EN. Rev 1.0                   |
// +--------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 7372800,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              framing_err,
  output logic              overrun_err,
  output logic              busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] C_S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] C_S_LO   = SW'(M - 1);
  localparam logic [SW-1:0] C_S_MID  = SW'(M);
  localparam logic [SW-1:0] C_S_DEC  = SW'(M + 1);

  logic              rx_meta_q, rx_s_q;
  logic [ST_W-1:0]   state_q, state_d;
  logic [SW-1:0]     s_cnt_q, s_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic              brk_q, brk_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              fe_q, fe_d, ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d, pe_q, pe_d;
`endif

  logic          div_clr, tick, vote, dec, wrap;
  logic [SW-1:0] s_inc;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst),
    .clr   (div_clr),
    .tick  (tick)
  );

  assign s_inc = (s_cnt_q == C_S_LAST) ? '0 : s_cnt_q + 1'b1;
  assign dec   = tick && (s_inc == C_S_DEC);
  assign wrap  = tick && (s_inc == '0);
  // Third vote sample is the live line value at the decision tick.
  assign vote  = maj3(v0_q, v1_q, rx_s_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= ST_IDLE;
      s_cnt_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      brk_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      brk_q      <= brk_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      pe_q       <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = tick ? s_inc : s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    v0_d       = (tick && (s_inc == C_S_LO))  ? rx_s_q : v0_q;
    v1_d       = (tick && (s_inc == C_S_MID)) ? rx_s_q : v1_q;
    brk_d      = brk_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    div_clr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    pe_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          div_clr   = 1'b1;
          s_cnt_d   = '0;
          bit_cnt_d = '0;
          brk_d     = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (dec) begin
          bit_cnt_d = '0;
          state_d   = vote ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        // bit_cnt counts decided bits, so the start period's wrap is ignored.
        if (dec) begin
          shreg_d   = {vote, shreg_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (wrap && (bit_cnt_q == 4'(DATA_W))) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (dec) begin
          par_d = vote;
        end else if (wrap) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (brk_q) begin
          if (rx_s_q) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (dec) begin
          if (!vote) begin
            fe_d  = 1'b1;
            brk_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_q != ^shreg_q) begin
              pe_d = 1'b1;
            end else
`endif
            if (fifo_full) begin
              ov_d = 1'b1;
            end else begin
              rx_valid_d = 1'b1;
              rx_data_d  = shreg_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    rx_data     = rx_data_q;
    rx_valid    = rx_valid_q;
    framing_err = fe_q;
    overrun_err = ov_q;
`ifdef UART_RX_PARITY_EN
    parity_err  = pe_q;
`endif
  end

endmodule
`default_nettype wire
